aes_key_schedule: RTL and testbench
===================================

Name: aes_key_schedule

Overview:
Iterative, multi-length AES key expansion engine; successor to the single-round combinational key processor.
- Accepts a 128/192/256-bit cipher key and generates one 32-bit schedule word per clock per FIPS-197.
- Stores all round keys in an internal buffer for random-access reads by the cipher datapath.
- Sits between key load logic and the round pipeline; round index drives the read port.

Parameters:
KEY_BITS_MAX, 256, largest key length accepted (128, 192 or 256); sizes the buffer to 4*(Nr_max+1) words.
OUT_REG, 1, 1 = rk_out registered (1-cycle read latency); 0 = combinational read.

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request expansion; sampled only when busy=0
key_len  in  2  0=128, 1=192, 2=256; 3 illegal
key_in  in  256  cipher key, left-aligned; word 0 = key_in[255:224]; unused LSBs ignored
busy  out  1  expansion in progress
done  out  1  one-cycle pulse when last word written
key_ready  out  1  buffer holds a complete schedule
err  out  1  one-cycle pulse on illegal start
rk_idx  in  4  round key index 0..Nr
rk_out  out  128  round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}, w[4r] in MSBs

Behaviour:
- Modes: Nk/Nr/Nw = 4/10/44, 6/12/52, 8/14/60.
- Reset values: busy=0, done=0, key_ready=0, err=0, rk_out=0, FSM=IDLE, rcon=0x01. Buffer contents are don't-care.
- FSM states are IDLE and EXPAND.
- IDLE + start + legal key_len:
  - Store key words 0..Nk-1 into the buffer and into an 8-word sliding window.
  - Set word index i=Nk, Nk-phase counter j=0, rcon=0x01.
  - Set busy=1, key_ready=0; go to EXPAND.
- IDLE + start + illegal key_len: illegal means 3, or longer than KEY_BITS_MAX.
  - err=1 for one cycle.
  - No other state change; previous schedule and key_ready are preserved.
- EXPAND computes one word per edge from temp = w[i-1]:
  - If j==0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}, then rcon = xtime(rcon), i.e. shift left 1 and XOR 0x1b on carry-out.
  - Else if Nk==8 and j==4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp. Write w[i] to buffer[i], shift the window, i++, j = (j==Nk-1)?0:j+1.
- Completion: the edge writing w[Nw-1] is the (Nw-Nk)-th edge after the start edge (40/46/52 edges). Registered outputs change on that edge: busy=0, done=1 (one cycle), key_ready=1, FSM=IDLE.
- No divide/modulo hardware: phase counter j and rcon register only.
- start while busy is ignored (no err); key_in and key_len are sampled only on the accept edge.
- Reads:
  - rk_out reflects buffer[4*rk_idx .. 4*rk_idx+3]: one cycle later if OUT_REG=1, same cycle if OUT_REG=0.
  - rk_idx > Nr of the last accepted mode gives rk_out=0.
  - Reads during busy return partially written contents; this is legal but the data is not guaranteed.
- rst mid-expansion:
  - Aborts to IDLE with all outputs at reset values (key_ready=0).
  - A following start runs a full fresh expansion.
- Simultaneous rst and start: rst wins.
- Back-to-back: start asserted in the cycle done is high is accepted, since busy is already 0.

Decomposition:
- Package aes_pkg holds:
  - Key-length enum (KL_128, KL_192, KL_256).
  - Per-mode Nk/Nr/Nw constants.
  - RCON_INIT=0x01 and the xtime function.
  - S-box table function.
- One sub-module, aes_sub_word: 32-bit combinational SubWord built from four S-box lookups.
  - Instantiate it once; the j==0 and Nk==8,j==4 paths share it via an input mux (RotWord applied before the mux).

Test Plan:
- Reset behaviour: rst held for 3 cycles, then released -> busy=0, done=0, key_ready=0, rk_out=0.
- AES-128 vector:
  - Stimulus: key_len=0, key 2b7e1516 28aed2a6 abf71588 09cf4f3c.
  - Response: done exactly 40 edges after the start edge.
  - rk_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6; rk_idx=0 echoes the key.
- AES-192 vector:
  - Stimulus: key_len=1, key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b.
  - Response: done after 46 edges; rk_idx=12 gives e98ba06f448c773c8ecc720401002202.
- AES-256 vector:
  - Stimulus: key_len=2, key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4.
  - Response: done after 52 edges; rk_idx=14 gives fe4890d1e6188d0b046df344706c631e.
- Illegal and busy starts:
  - key_len=3 -> err pulse, busy stays 0, prior round keys unchanged.
  - start re-asserted at edge 10 of an expansion -> ignored; final keys match the original vector.
- Reset mid-expansion:
  - rst at edge 20 of an AES-256 expansion -> key_ready=0, busy=0.
  - A following AES-128 start yields the correct 40-edge result.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types, per-mode constants and byte-level helpers for the AES key schedule.
package aes_pkg;

    typedef enum logic [1:0] {
        KL_128 = 2'd0,
        KL_192 = 2'd1,
        KL_256 = 2'd2
    } key_len_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } ks_state_e;

    localparam logic [3:0] NK_128 = 4'd4;
    localparam logic [3:0] NK_192 = 4'd6;
    localparam logic [3:0] NK_256 = 4'd8;
    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;
    localparam logic [5:0] NW_128 = 6'd44;
    localparam logic [5:0] NW_192 = 6'd52;
    localparam logic [5:0] NW_256 = 6'd60;

    localparam logic [7:0] RCON_INIT = 8'h01;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Multiply by x in GF(2^8); used to step the round constant.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [3:0] mode_nk(input key_len_e m);
        case (m)
            KL_192:  return NK_192;
            KL_256:  return NK_256;
            default: return NK_128;
        endcase
    endfunction

    function automatic logic [3:0] mode_nr(input key_len_e m);
        case (m)
            KL_192:  return NR_192;
            KL_256:  return NR_256;
            default: return NR_128;
        endcase
    endfunction

    function automatic logic [5:0] mode_nw(input key_len_e m);
        case (m)
            KL_192:  return NW_192;
            KL_256:  return NW_256;
            default: return NW_128;
        endcase
    endfunction

    // Buffer depth in words for the largest key length a build accepts.
    function automatic int nw_for_bits(input int key_bits);
        if (key_bits >= 256) return 60;
        if (key_bits >= 192) return 52;
        return 44;
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Combinational SubWord: four parallel S-box lookups on a 32-bit word.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    assign word_out = {sbox(word_in[31:24]), sbox(word_in[23:16]),
                       sbox(word_in[15:8]),  sbox(word_in[7:0])};

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES key expansion: one schedule word per clock into a round-key buffer
// that the cipher datapath reads one 128-bit round key at a time.
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int KEY_BITS_MAX = 256,
    parameter bit OUT_REG      = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         key_ready,
    output logic         err,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_out
);

    localparam int NW_MAX = nw_for_bits(KEY_BITS_MAX);
    localparam int NR_MAX = NW_MAX / 4 - 1;

    ks_state_e    state_q, state_d;
    key_len_e     mode_q, mode_d;
    logic [5:0]   i_q, i_d;
    logic [2:0]   j_q, j_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [255:0] win_q, win_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         key_ready_q, key_ready_d;
    logic         err_q, err_d;
    logic [31:0]  mem_q [NW_MAX];
    logic [31:0]  mem_d [NW_MAX];

    logic         legal_len;
    logic [3:0]   nk;
    logic [31:0]  prev_word;
    logic [31:0]  old_word;
    logic [31:0]  sub_in;
    logic [31:0]  sub_out;
    logic [31:0]  temp;
    logic [31:0]  new_word;
    logic [127:0] rk_out_d;

    assign legal_len = (key_len != 2'd3) && ((128 + 64 * int'(key_len)) <= KEY_BITS_MAX);

    // The window keeps the newest word in its lowest slot, so w[i-1] is fixed and
    // w[i-Nk] sits Nk slots up; RotWord is applied ahead of the shared S-box mux.
    always_comb begin
        nk        = mode_nk(mode_q);
        prev_word = win_q[31:0];
        case (mode_q)
            KL_192:  old_word = win_q[191:160];
            KL_256:  old_word = win_q[255:224];
            default: old_word = win_q[127:96];
        endcase
        sub_in = (j_q == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
        temp   = prev_word;
        if (j_q == 3'd0) begin
            temp = sub_out ^ {rcon_q, 24'h0};
        end else if (mode_q == KL_256 && j_q == 3'd4) begin
            temp = sub_out;
        end
        new_word = old_word ^ temp;
    end

    aes_sub_word u_sub_word (
        .word_in  (sub_in),
        .word_out (sub_out)
    );

    // Next-state logic: key load on an accepted start, one expansion step per cycle otherwise.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        i_d         = i_q;
        j_d         = j_q;
        rcon_d      = rcon_q;
        win_d       = win_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        key_ready_d = key_ready_q;
        err_d       = 1'b0;
        mem_d       = mem_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (legal_len) begin
                        mode_d = key_len_e'(key_len);
                        for (int k = 0; k < 8; k++) begin
                            if (4'(k) < mode_nk(key_len_e'(key_len))) begin
                                mem_d[k] = key_in[255 - 32 * k -: 32];
                            end
                        end
                        case (key_len)
                            2'd1:    win_d = {64'h0, key_in[255:64]};
                            2'd2:    win_d = key_in;
                            default: win_d = {128'h0, key_in[255:128]};
                        endcase
                        i_d         = {2'b00, mode_nk(key_len_e'(key_len))};
                        j_d         = 3'd0;
                        rcon_d      = RCON_INIT;
                        busy_d      = 1'b1;
                        key_ready_d = 1'b0;
                        state_d     = ST_EXPAND;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_EXPAND: begin
                for (int k = 0; k < NW_MAX; k++) begin
                    if (i_q == 6'(k)) begin
                        mem_d[k] = new_word;
                    end
                end
                win_d = {win_q[223:0], new_word};
                i_d   = i_q + 6'd1;
                j_d   = ({1'b0, j_q} == nk - 4'd1) ? 3'd0 : j_q + 3'd1;
                if (j_q == 3'd0) begin
                    rcon_d = xtime(rcon_q);
                end
                if (i_q == mode_nw(mode_q) - 6'd1) begin
                    state_d     = ST_IDLE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    key_ready_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, control and buffer registers; the buffer is cleared too so reads after reset are zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= KL_128;
            i_q         <= '0;
            j_q         <= '0;
            rcon_q      <= RCON_INIT;
            win_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            key_ready_q <= 1'b0;
            err_q       <= 1'b0;
            for (int k = 0; k < NW_MAX; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            i_q         <= i_d;
            j_q         <= j_d;
            rcon_q      <= rcon_d;
            win_q       <= win_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            key_ready_q <= key_ready_d;
            err_q       <= err_d;
            mem_q       <= mem_d;
        end
    end

    // Round-key read mux; indices beyond Nr of the current mode read as zero.
    always_comb begin
        rk_out_d = '0;
        for (int r = 0; r <= NR_MAX; r++) begin
            if (rk_idx == 4'(r) && rk_idx <= mode_nr(mode_q)) begin
                rk_out_d = {mem_q[4 * r], mem_q[4 * r + 1], mem_q[4 * r + 2], mem_q[4 * r + 3]};
            end
        end
    end

    generate
        if (OUT_REG) begin : g_out_reg
            logic [127:0] rk_out_q;
            // Registered read port for one-cycle read latency.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rk_out_q <= '0;
                end else begin
                    rk_out_q <= rk_out_d;
                end
            end
            assign rk_out = rk_out_q;
        end else begin : g_out_comb
            assign rk_out = rk_out_d;
        end
    endgenerate

    assign busy      = busy_q;
    assign done      = done_q;
    assign key_ready = key_ready_q;
    assign err       = err_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed self-checking bench for aes_key_schedule using FIPS-197 key expansion vectors.
module tb_aes_key_schedule;

    logic         clk;
    logic         rst;
    logic         start;
    logic [1:0]   key_len;
    logic [255:0] key_in;
    logic         busy;
    logic         done;
    logic         key_ready;
    logic         err;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;

    int checks;
    int failures;

    localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    localparam logic [127:0] RK128_0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] RK128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] RK128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] RK192_1  = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
    localparam logic [127:0] RK192_12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] RK256_1  = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] RK256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

    aes_key_schedule #(
        .KEY_BITS_MAX (256),
        .OUT_REG      (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_len   (key_len),
        .key_in    (key_in),
        .busy      (busy),
        .done      (done),
        .key_ready (key_ready),
        .err       (err),
        .rk_idx    (rk_idx),
        .rk_out    (rk_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic start_expansion(input logic [1:0] len, input logic [255:0] key);
        @(negedge clk);
        key_len = len;
        key_in  = key;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int edges);
        edges = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                edges = n;
                break;
            end
        end
    endtask

    task automatic read_rk(input logic [3:0] idx, output logic [127:0] data);
        @(negedge clk);
        rk_idx = idx;
        @(posedge clk);
        #1;
        data = rk_out;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
        checks++; if (key_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_key_ready got=%b exp=0", key_ready); end
        checks++; if (rk_out !== 128'h0) begin failures++; $display("[TB] FAIL reset_rk_out got=%h exp=0", rk_out); end
    endtask

    task automatic test_aes128;
        int edges;
        logic [127:0] d;
        start_expansion(2'd0, KEY128);
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL a128_busy got=%b exp=1", busy); end
        wait_done(edges);
        checks++; if (edges !== 40) begin failures++; $display("[TB] FAIL a128_done_edge got=%0d exp=40", edges); end
        checks++; if (key_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("[TB] FAIL a128_flags got ready=%b busy=%b exp ready=1 busy=0", key_ready, busy); end
        read_rk(4'd0, d);
        checks++; if (d !== RK128_0) begin failures++; $display("[TB] FAIL a128_rk0 got=%h exp=%h", d, RK128_0); end
        read_rk(4'd1, d);
        checks++; if (d !== RK128_1) begin failures++; $display("[TB] FAIL a128_rk1 got=%h exp=%h", d, RK128_1); end
        read_rk(4'd10, d);
        checks++; if (d !== RK128_10) begin failures++; $display("[TB] FAIL a128_rk10 got=%h exp=%h", d, RK128_10); end
        read_rk(4'd11, d);
        checks++; if (d !== 128'h0) begin failures++; $display("[TB] FAIL a128_rk11 got=%h exp=0", d); end
    endtask

    task automatic test_aes192;
        int edges;
        logic [127:0] d;
        start_expansion(2'd1, KEY192);
        wait_done(edges);
        checks++; if (edges !== 46) begin failures++; $display("[TB] FAIL a192_done_edge got=%0d exp=46", edges); end
        read_rk(4'd1, d);
        checks++; if (d !== RK192_1) begin failures++; $display("[TB] FAIL a192_rk1 got=%h exp=%h", d, RK192_1); end
        read_rk(4'd12, d);
        checks++; if (d !== RK192_12) begin failures++; $display("[TB] FAIL a192_rk12 got=%h exp=%h", d, RK192_12); end
        read_rk(4'd13, d);
        checks++; if (d !== 128'h0) begin failures++; $display("[TB] FAIL a192_rk13 got=%h exp=0", d); end
    endtask

    task automatic test_aes256;
        int edges;
        logic [127:0] d;
        start_expansion(2'd2, KEY256);
        wait_done(edges);
        checks++; if (edges !== 52) begin failures++; $display("[TB] FAIL a256_done_edge got=%0d exp=52", edges); end
        read_rk(4'd1, d);
        checks++; if (d !== RK256_1) begin failures++; $display("[TB] FAIL a256_rk1 got=%h exp=%h", d, RK256_1); end
        read_rk(4'd14, d);
        checks++; if (d !== RK256_14) begin failures++; $display("[TB] FAIL a256_rk14 got=%h exp=%h", d, RK256_14); end
    endtask

    task automatic test_illegal_start;
        logic [127:0] d;
        start_expansion(2'd3, KEY128);
        checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL illegal_err got=%b exp=1", err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL illegal_busy got=%b exp=0", busy); end
        @(posedge clk);
        #1;
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL illegal_err_pulse got=%b exp=0", err); end
        checks++; if (key_ready !== 1'b1) begin failures++; $display("[TB] FAIL illegal_key_ready got=%b exp=1", key_ready); end
        read_rk(4'd14, d);
        checks++; if (d !== RK256_14) begin failures++; $display("[TB] FAIL illegal_rk14_kept got=%h exp=%h", d, RK256_14); end
    endtask

    task automatic test_busy_start;
        int edges;
        logic err_seen;
        logic [127:0] d;
        edges    = -1;
        err_seen = 1'b0;
        start_expansion(2'd0, KEY128);
        for (int n = 1; n <= 200; n++) begin
            if (n == 10) begin
                key_len = 2'd2;
                key_in  = KEY256;
                start   = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (err) err_seen = 1'b1;
            if (done) begin
                edges = n;
                break;
            end
        end
        checks++; if (edges !== 40) begin failures++; $display("[TB] FAIL busy_start_done_edge got=%0d exp=40", edges); end
        checks++; if (err_seen !== 1'b0) begin failures++; $display("[TB] FAIL busy_start_err got=%b exp=0", err_seen); end
        read_rk(4'd10, d);
        checks++; if (d !== RK128_10) begin failures++; $display("[TB] FAIL busy_start_rk10 got=%h exp=%h", d, RK128_10); end
    endtask

    task automatic test_reset_mid;
        int edges;
        logic [127:0] d;
        start_expansion(2'd2, KEY256);
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (key_ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_key_ready got=%b exp=0", key_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_done got=%b exp=0", done); end
        start_expansion(2'd0, KEY128);
        wait_done(edges);
        checks++; if (edges !== 40) begin failures++; $display("[TB] FAIL rst_mid_done_edge got=%0d exp=40", edges); end
        read_rk(4'd10, d);
        checks++; if (d !== RK128_10) begin failures++; $display("[TB] FAIL rst_mid_rk10 got=%h exp=%h", d, RK128_10); end
    endtask

    task automatic test_back_to_back;
        int edges;
        logic [127:0] d;
        start_expansion(2'd1, KEY192);
        wait_done(edges);
        checks++; if (edges !== 46) begin failures++; $display("[TB] FAIL b2b_first_edge got=%0d exp=46", edges); end
        key_len = 2'd2;
        key_in  = KEY256;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL b2b_accept_busy got=%b exp=1", busy); end
        wait_done(edges);
        checks++; if (edges !== 52) begin failures++; $display("[TB] FAIL b2b_second_edge got=%0d exp=52", edges); end
        read_rk(4'd14, d);
        checks++; if (d !== RK256_14) begin failures++; $display("[TB] FAIL b2b_rk14 got=%h exp=%h", d, RK256_14); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        key_len  = 2'd0;
        key_in   = '0;
        rk_idx   = 4'd0;
        test_reset();
        test_aes128();
        test_aes192();
        test_aes256();
        test_illegal_start();
        test_busy_start();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
